llc_mem_responder: RTL and testbench

// - Memory-side endpoint of the LLC memory interface: accepts llc_mem_req beats, returns llc_mem_rsp lines for reads.
// - Line-granular backing store with configurable read latency, in-order service and a request queue.
// - Used as the off-chip memory model under the LLC in unit and cache-hierarchy benches; synthesizable for FPGA bring-up.

---
 rtl/llc_mem_responder_pkg.sv | 43 ++++
 rtl/llc_mem_responder_req_fifo.sv | 86 ++++++++
 rtl/llc_mem_responder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_llc_mem_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// llc_mem_responder_pkg
// Shared LLC <-> memory interface types and constants.
//   line_t         : one cache line of data
//   line_addr_t    : line-granular address
//   llc_mem_req_t  : {hwrite, hsize, hprot, addr, line}
//   llc_mem_rsp_t  : {line}
//   sat_inc32      : saturating 32-bit increment used by statistics counters
// ----------------------------------------------------------------------------
package llc_mem_responder_pkg;

    localparam int LINE_ADDR_BITS = 26;
    localparam int BITS_PER_LINE  = 128;
    localparam int HSIZE_BITS     = 3;
    localparam int HPROT_BITS     = 2;

    typedef logic [BITS_PER_LINE-1:0]  line_t;
    typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;

    typedef struct packed {
        logic                  hwrite;
        logic [HSIZE_BITS-1:0] hsize;
        logic [HPROT_BITS-1:0] hprot;
        line_addr_t            addr;
        line_t                 line;
    } llc_mem_req_t;

    typedef struct packed {
        line_t line;
    } llc_mem_rsp_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/llc_mem_responder_req_fifo.sv
// ----------------------------------------------------------------------------
// llc_mem_req_fifo
// Parameterised synchronous FIFO with registered full/empty flags.
// Pushes while full and pops while empty are ignored. Push and pop in the
// same cycle leave the occupancy unchanged.
// Ports:
//   clk, rst        clock, synchronous active-high reset (flushes contents)
//   push, wdata     write strobe and data
//   pop, rdata      read strobe; rdata shows the head entry combinationally
//   full, empty     registered occupancy flags
// ----------------------------------------------------------------------------
module llc_mem_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             full_r;
    logic             empty_r;
    logic             push_s;
    logic             pop_s;

    assign push_s = push && !full_r;
    assign pop_s  = pop && !empty_r;

    // Next occupancy from the qualified push/pop strobes.
    always_comb begin
        cnt_s = cnt_r;
        if (push_s && !pop_s) begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (!push_s && pop_s) begin
            cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Pointers, occupancy and the registered full/empty flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            cnt_r   <= cnt_s;
            full_r  <= (cnt_s == CNT_W'(DEPTH));
            empty_r <= (cnt_s == '0);
        end
    end

    // Entry storage; contents need no reset because the flags gate access.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/llc_mem_responder.sv
// ----------------------------------------------------------------------------
// llc_mem_responder
// Memory-side endpoint of the LLC memory interface. Requests are queued in
// a small FIFO and serviced strictly in order against a line-granular
// backing store. Writes complete in one cycle; reads return one line after a
// fixed latency, one read outstanding at a time. After reset the store is
// zero-filled, one line per cycle, before any request is accepted.
//
// Parameters: MEM_LINES (power of 2), READ_LAT (1..255), REQ_Q_DEPTH (pow2>=2)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   llc_mem_req_valid/ready  request handshake
//   llc_mem_req_i            request beat {hwrite, hsize, hprot, addr, line}
//   llc_mem_rsp_valid/ready  read response handshake
//   llc_mem_rsp_o            read response {line}
//   init_done                zero-fill complete
// Optional (macro MEM_RSP_STATS_EN):
//   stat_rd_cnt, stat_wr_cnt  reads / writes dequeued (saturating)
//   stat_stall_cnt            cycles of request valid && !ready after init
// ----------------------------------------------------------------------------
module llc_mem_responder
    import llc_mem_responder_pkg::*;
#(
    parameter int MEM_LINES   = 1024,
    parameter int READ_LAT    = 4,
    parameter int REQ_Q_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         llc_mem_req_valid,
    output logic         llc_mem_req_ready,
    input  llc_mem_req_t llc_mem_req_i,
    output logic         llc_mem_rsp_valid,
    input  logic         llc_mem_rsp_ready,
    output llc_mem_rsp_t llc_mem_rsp_o,
    output logic         init_done
`ifdef MEM_RSP_STATS_EN
    ,
    output logic [31:0]  stat_rd_cnt,
    output logic [31:0]  stat_wr_cnt,
    output logic [31:0]  stat_stall_cnt
`endif
);

    localparam int         IDX_W   = $clog2(MEM_LINES);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MEM_LINES - 1);
    localparam logic [7:0] LAT_M1  = 8'(READ_LAT - 1);
    localparam bit         LAT_ONE = (READ_LAT == 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_s;
    logic [IDX_W-1:0] rd_idx_r;
    logic [IDX_W-1:0] rd_idx_s;
    // Cycles left until the response becomes visible; the line is captured
    // from the store on the cycle where this reaches 1 so that valid rises
    // exactly READ_LAT cycles after the pop.
    logic [7:0]       cnt_r;
    logic [7:0]       cnt_s;
    logic             init_done_r;
    logic             init_done_s;
    logic             rsp_valid_r;
    logic             rsp_valid_s;
    line_t            rsp_line_r;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             push_s;
    logic             pop_s;
    logic [$bits(llc_mem_req_t)-1:0] fifo_rdata_s;
    llc_mem_req_t     head_s;
    logic [IDX_W-1:0] head_idx_s;

    logic             mem_we_s;
    logic             mem_re_s;
    logic [IDX_W-1:0] mem_idx_s;
    line_t            mem_wdata_s;
    line_t            store_r [MEM_LINES];

    logic             unused_s;

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    assign llc_mem_req_ready = init_done_r && !fifo_full_s;
    assign push_s            = llc_mem_req_valid && llc_mem_req_ready;

    llc_mem_req_fifo #(
        .WIDTH ($bits(llc_mem_req_t)),
        .DEPTH (REQ_Q_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (llc_mem_req_i),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign head_s     = llc_mem_req_t'(fifo_rdata_s);
    // Upper address bits are dropped on purpose: addresses alias modulo MEM_LINES.
    assign head_idx_s = head_s.addr[IDX_W-1:0];

    // hsize/hprot travel through the queue but the store only does full lines.
    assign unused_s = ^{head_s.hsize, head_s.hprot, head_s.addr[LINE_ADDR_BITS-1:IDX_W]};

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // Next-state, store port control and next response state.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        rd_idx_s    = rd_idx_r;
        cnt_s       = cnt_r;
        init_done_s = init_done_r;
        rsp_valid_s = rsp_valid_r;
        pop_s       = 1'b0;
        mem_we_s    = 1'b0;
        mem_re_s    = 1'b0;
        mem_idx_s   = rd_idx_r;
        mem_wdata_s = '0;
        case (state_r)
            ST_INIT: begin
                // Zero-fill shares the single write port with request writes.
                mem_we_s  = 1'b1;
                mem_idx_s = idx_r;
                if (idx_r == IDX_MAX) begin
                    idx_s       = '0;
                    init_done_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    idx_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    mem_idx_s = head_idx_s;
                    if (head_s.hwrite) begin
                        mem_we_s    = 1'b1;
                        mem_wdata_s = head_s.line;
                        state_s     = ST_IDLE;
                    end else begin
                        rd_idx_s = head_idx_s;
                        cnt_s    = LAT_M1;
                        if (LAT_ONE) begin
                            // Single-cycle latency: capture the line on the pop itself.
                            mem_re_s    = 1'b1;
                            rsp_valid_s = 1'b1;
                            state_s     = ST_RSP;
                        end else begin
                            state_s = ST_WAIT;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                mem_idx_s = rd_idx_r;
                if (cnt_r <= 8'd1) begin
                    mem_re_s    = 1'b1;
                    rsp_valid_s = 1'b1;
                    cnt_s       = 8'd0;
                    state_s     = ST_RSP;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ST_RSP: begin
                if (llc_mem_rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_RSP;
                end
            end
            default: begin
                state_s     = ST_INIT;
                idx_s       = '0;
                init_done_s = 1'b0;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // FSM and response-control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_INIT;
            idx_r       <= '0;
            rd_idx_r    <= '0;
            cnt_r       <= 8'd0;
            init_done_r <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            rd_idx_r    <= rd_idx_s;
            cnt_r       <= cnt_s;
            init_done_r <= init_done_s;
            rsp_valid_r <= rsp_valid_s;
        end
    end

    // ------------------------------------------------------------------
    // Backing store (single port, no reset so it maps onto block RAM)
    // ------------------------------------------------------------------

    // Store write port: zero-fill during INIT, request writes in IDLE.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            store_r[mem_idx_s] <= mem_wdata_s;
        end
    end

    // Registered read port feeding the response line; held while in RSP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_line_r <= '0;
        end else if (mem_re_s) begin
            rsp_line_r <= store_r[mem_idx_s];
        end
    end

    assign llc_mem_rsp_valid  = rsp_valid_r;
    assign llc_mem_rsp_o.line = rsp_line_r;
    assign init_done          = init_done_r;

`ifdef MEM_RSP_STATS_EN
    logic [31:0] stat_rd_r;
    logic [31:0] stat_wr_r;
    logic [31:0] stat_stall_r;

    // Saturating statistics; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_r    <= 32'd0;
            stat_wr_r    <= 32'd0;
            stat_stall_r <= 32'd0;
        end else begin
            if (pop_s && !head_s.hwrite) begin
                stat_rd_r <= sat_inc32(stat_rd_r);
            end
            if (pop_s && head_s.hwrite) begin
                stat_wr_r <= sat_inc32(stat_wr_r);
            end
            if (llc_mem_req_valid && !llc_mem_req_ready && init_done_r) begin
                stat_stall_r <= sat_inc32(stat_stall_r);
            end
        end
    end

    assign stat_rd_cnt    = stat_rd_r;
    assign stat_wr_cnt    = stat_wr_r;
    assign stat_stall_cnt = stat_stall_r;
`endif

endmodule

// File: tb/tb_llc_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_llc_mem_responder
// Self-checking bench for llc_mem_responder. A negedge monitor keeps a line
// model updated by accepted writes and pushes the expected line for each
// accepted read; responses are popped and compared on handshake.
// ----------------------------------------------------------------------------
module tb_llc_mem_responder;
    import llc_mem_responder_pkg::*;

    localparam int MEM_LINES   = 1024;
    localparam int READ_LAT    = 4;
    localparam int REQ_Q_DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    llc_mem_req_t req;
    logic         rsp_valid;
    logic         rsp_ready;
    llc_mem_rsp_t rsp;
    logic         init_done;
`ifdef MEM_RSP_STATS_EN
    logic [31:0]  stat_rd_cnt;
    logic [31:0]  stat_wr_cnt;
    logic [31:0]  stat_stall_cnt;
`endif

    int    n_cmp = 0;
    int    n_err = 0;
    line_t exp_q[$];
    line_t model [MEM_LINES];
    int    wr_seen = 0;
    int    rd_seen = 0;
    int    stall_seen = 0;

    always #5 clk = ~clk;

    llc_mem_responder #(
        .MEM_LINES   (MEM_LINES),
        .READ_LAT    (READ_LAT),
        .REQ_Q_DEPTH (REQ_Q_DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .llc_mem_req_valid (req_valid),
        .llc_mem_req_ready (req_ready),
        .llc_mem_req_i     (req),
        .llc_mem_rsp_valid (rsp_valid),
        .llc_mem_rsp_ready (rsp_ready),
        .llc_mem_rsp_o     (rsp),
        .init_done         (init_done)
`ifdef MEM_RSP_STATS_EN
        ,
        .stat_rd_cnt       (stat_rd_cnt),
        .stat_wr_cnt       (stat_wr_cnt),
        .stat_stall_cnt    (stat_stall_cnt)
`endif
    );

    task automatic check_val(input string tag, input line_t got, input line_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor, sampling mid-cycle on the falling edge.
    line_t mon_exp;
    int    mon_idx;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                for (int i = 0; i < MEM_LINES; i++) model[i] = '0;
                wr_seen = 0;
                rd_seen = 0;
                stall_seen = 0;
            end else begin
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("rsp_unexpected", 1, 0);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check_val("rsp_line", rsp.line, mon_exp);
                    end
                end
                if (req_valid && req_ready) begin
                    mon_idx = int'(req.addr) % MEM_LINES;
                    if (req.hwrite) begin
                        model[mon_idx] = req.line;
                        wr_seen++;
                    end else begin
                        exp_q.push_back(model[mon_idx]);
                        rd_seen++;
                    end
                end
                if (req_valid && !req_ready && init_done) stall_seen++;
            end
        end
    end

    task automatic send_req(input logic wr, input line_addr_t a, input line_t d);
        int   n;
        logic hs;
        req_valid  = 1'b1;
        req.hwrite = wr;
        req.hsize  = 3'd4;
        req.hprot  = 2'd1;
        req.addr   = a;
        req.line   = d;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 2000) begin
            hs = req_ready;
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        if (!hs) check_val("req_timeout", 1, 0);
    endtask

    task automatic wait_init(input string tag);
        int   n;
        logic ready_bad;
        n = 0;
        ready_bad = 1'b0;
        while (!init_done && n < 3000) begin
            if (req_ready) ready_bad = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, "_cycles"}, n, MEM_LINES);
        check_val({tag, "_ready_low"}, ready_bad, 0);
    endtask

    task automatic measure_lat(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val(tag, n, READ_LAT);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check_val(tag, exp_q.size(), 0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        line_t held;
        logic  hold_bad;
        rst       = 1'b1;
        req_valid = 1'b0;
        req       = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_line", rsp.line, 0);
        check_val("rst_init_done", init_done, 0);

        wait_init("init");
        check_val("ready_after_init", req_ready, 1);

        // Read of a freshly zeroed line.
        send_req(1'b0, 26'h10, '0);
        measure_lat("lat_read_zero");
        check_val("read_zero_line", rsp.line, 0);
        drain("drain_read_zero");

        // Write then read back-to-back.
        send_req(1'b1, 26'h25, {16{8'hA5}});
        send_req(1'b0, 26'h25, '0);
        measure_lat("lat_wr_rd");
        check_val("wr_rd_line", rsp.line, {16{8'hA5}});
        drain("drain_wr_rd");

        // Response held off while the queue fills.
        rsp_ready = 1'b0;
        send_req(1'b0, 26'h25, '0);
        measure_lat("lat_stall");
        held = rsp.line;
        send_req(1'b1, 26'h30, {4{32'h3030_CAFE}});
        send_req(1'b0, 26'h30, '0);
        send_req(1'b1, 26'h31, {4{32'h3131_BEEF}});
        send_req(1'b0, 26'h31, '0);
        check_val("fifo_full_ready", req_ready, 0);
        hold_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!rsp_valid || rsp.line !== held) hold_bad = 1'b1;
            @(posedge clk); #1;
        end
        check_val("rsp_hold_stable", hold_bad, 0);
        check_val("rsp_hold_line", rsp.line, {16{8'hA5}});
        rsp_ready = 1'b1;
        drain("drain_stall");

        // Upper address bits alias onto the same line.
        send_req(1'b1, 26'h003, {4{32'h0003_D00D}});
        send_req(1'b0, 26'h403, '0);
        measure_lat("lat_alias");
        check_val("alias_line", rsp.line, {4{32'h0003_D00D}});
        drain("drain_alias");

`ifdef MEM_RSP_STATS_EN
        check_val("stat_wr", stat_wr_cnt, wr_seen);
        check_val("stat_rd", stat_rd_cnt, rd_seen);
        check_val("stat_stall", stat_stall_cnt, stall_seen);
`endif

        // Reset while a read waits and three requests are queued.
        send_req(1'b0, 26'h50, '0);
        send_req(1'b1, 26'h60, {4{32'h6060_1111}});
        send_req(1'b1, 26'h10, {4{32'h1010_2222}});
        send_req(1'b0, 26'h60, '0);
        check_val("wait_not_valid", rsp_valid, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("midrst_rsp_valid", rsp_valid, 0);
        check_val("midrst_req_ready", req_ready, 0);
        check_val("midrst_init_done", init_done, 0);
        check_val("midrst_rsp_line", rsp.line, 0);
        rst = 1'b0;
        wait_init("reinit");
        send_req(1'b0, 26'h60, '0);
        measure_lat("lat_after_rst");
        check_val("after_rst_line", rsp.line, 0);
        send_req(1'b0, 26'h10, '0);
        drain("drain_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
